// File: rtl/regs_dump_tx.sv
// regs_dump_tx: walks registers 0..NREGS-1 and sends each as a UART frame (start, n data bits LSB-first, stop)
//   clk    : system clock, rising edge
//   Reset  : synchronous active-high reset
//   Start  : dump request, sampled while idle
//   Rdata  : register-file read data, combinational on Raddr
//   Raddr  : register-file read address
//   SerOut : serial line, idles high
//   Busy   : dump in progress (FETCH through DONE)
//   Done   : one-cycle pulse at the end of a dump
module regs_dump_tx #(
    parameter int n            = 8,
    parameter int NREGS        = 4,
    parameter int AW           = 2,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [n-1:0]  Rdata,
    output logic [AW-1:0] Raddr,
    output logic          SerOut,
    output logic          Busy,
    output logic          Done
);
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NW = n > 1 ? $clog2(n) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, DONE} state_t;

    state_t        state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [NW-1:0] bitcnt, bitcnt_n;
    logic [BW-1:0] baud, baud_n;
    logic [n-1:0]  sh, sh_n;
    logic          bit_end;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        bitcnt_n = bitcnt;
        sh_n     = sh;
        bit_end  = baud == BW'(CLKS_PER_BIT - 1);
        // baud counter only runs inside serial bits and restarts at every bit boundary
        baud_n   = (state inside {START, DATA, STOP}) && !bit_end ? baud + 1'b1 : '0;
        case (state)
            IDLE:  if (Start) state_n = FETCH;
            FETCH: begin
                sh_n    = Rdata;
                state_n = START;
            end
            START: if (bit_end) begin
                state_n  = DATA;
                bitcnt_n = '0;
            end
            DATA:  if (bit_end) begin
                if (bitcnt == NW'(n - 1)) state_n = STOP;
                else begin
                    bitcnt_n = bitcnt + 1'b1;
                    sh_n     = sh >> 1;
                end
            end
            STOP:  if (bit_end) begin
                if (idx == AW'(NREGS - 1)) state_n = DONE;
                else begin
                    idx_n   = idx + 1'b1;
                    state_n = FETCH;
                end
            end
            DONE:  begin
                state_n = IDLE;
                idx_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // outputs are registered from the next-state values so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (Reset) begin
            state  <= IDLE;
            idx    <= '0;
            bitcnt <= '0;
            baud   <= '0;
            sh     <= '0;
            SerOut <= 1'b1;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Raddr  <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            bitcnt <= bitcnt_n;
            baud   <= baud_n;
            sh     <= sh_n;
            SerOut <= state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
            Busy   <= state_n != IDLE;
            Done   <= state_n == DONE;
            Raddr  <= idx_n;
        end
    end
endmodule

// File: tb/tb_regs_dump_tx.sv
// tb_regs_dump_tx: scoreboard bench for regs_dump_tx (default timing plus a one-clock-per-bit instance)
module tb_regs_dump_tx;
    logic       clk = 1'b0;
    logic       Reset = 1'b1, Start = 1'b0, start_b = 1'b0;
    logic [7:0] regs [4];
    logic [7:0] Rdata, rdata_b;
    logic [1:0] Raddr, raddr_b;
    logic       SerOut, Busy, Done, ser_b, busy_b, done_b;

    always #5 clk = ~clk;

    assign Rdata   = regs[Raddr];
    assign rdata_b = 8'h81;

    regs_dump_tx dut (
        .clk(clk), .Reset(Reset), .Start(Start), .Rdata(Rdata),
        .Raddr(Raddr), .SerOut(SerOut), .Busy(Busy), .Done(Done)
    );

    regs_dump_tx #(.CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .Reset(Reset), .Start(start_b), .Rdata(rdata_b),
        .Raddr(raddr_b), .SerOut(ser_b), .Busy(busy_b), .Done(done_b)
    );

    int          checks = 0, fails = 0;
    logic [7:0]  exp_q [$];
    int          runs = 0, last_len = 0, last_done = 0, last_done_pos = 0, last_gap = 0, last_rn = 0;
    logic [15:0] last_rseq = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic flag(input string name, input string msg);
        checks++;
        fails++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // decodes SerOut frames (4 clocks per bit) and compares against the expected queue
    task automatic monitor();
        int         i = -1;
        int         fr = 0;
        logic [9:0] b = '0;
        logic       cur = 1'b1;
        logic       glitch = 1'b0;
        forever begin
            @(negedge clk);
            if (Reset) i = -1;
            else begin
                if (i < 0 && !SerOut) begin
                    i = 0;
                    glitch = 1'b0;
                end
                if (i >= 0) begin
                    if (i % 4 == 0) begin
                        b = {SerOut, b[9:1]};
                        cur = SerOut;
                    end else if (SerOut !== cur) glitch = 1'b1;
                    i++;
                    if (i == 40) begin
                        i = -1;
                        if (exp_q.size() == 0) flag($sformatf("frame %0d", fr), "unexpected frame");
                        else chk($sformatf("frame %0d {glitch,start,stop,data}", fr),
                                 64'({glitch, b[0], b[9], b[8:1]}), 64'({3'b001, exp_q.pop_front()}));
                        fr++;
                    end
                end
            end
        end
    endtask

    // measures each Busy run: length, Done count/position, distinct Raddr sequence, preceding idle gap
    task automatic tracker();
        logic        bq = 1'b0;
        int          len = 0, dn = 0, dpos = 0, gap = 0, rn = 0;
        logic [15:0] rs = '0;
        logic [1:0]  rl = '0;
        forever begin
            @(negedge clk);
            if (Busy) begin
                if (!bq) begin
                    last_gap = gap;
                    len = 0; dn = 0; dpos = 0; rn = 0; rs = '0;
                end
                len++;
                if (Done) begin
                    dn++;
                    dpos = len;
                end
                if (rn == 0 || Raddr != rl) begin
                    rs = {rs[13:0], Raddr};
                    rn++;
                    rl = Raddr;
                end
            end else begin
                if (bq) begin
                    last_len = len; last_done = dn; last_done_pos = dpos;
                    last_rseq = rs; last_rn = rn;
                    runs++;
                    gap = 0;
                end
                gap++;
            end
            bq = Busy;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 Start = 1'b1;
        @(posedge clk); #1 Start = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        @(negedge clk);
        for (int k = 0; k < 10 && !Busy; k++) @(negedge clk);
        if (!Busy) flag(name, "Busy never rose");
    endtask

    task automatic wait_run(input int r0, input string name);
        for (int k = 0; k < 1000 && runs == r0; k++) @(negedge clk);
        if (runs == r0) flag(name, "dump never finished");
    endtask

    task automatic check_dump(input string name);
        chk({name, " busy len"}, 64'(last_len), 64'd165);
        chk({name, " done count"}, 64'(last_done), 64'd1);
        chk({name, " done pos"}, 64'(last_done_pos), 64'd165);
        chk({name, " raddr seq"}, 64'({last_rn[7:0], last_rseq}), 64'h04_001B);
        chk({name, " frames left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset(input string name);
        chk({name, " SerOut"}, 64'(SerOut), 64'd1);
        chk({name, " Busy"}, 64'(Busy), 64'd0);
        chk({name, " Done"}, 64'(Done), 64'd0);
        chk({name, " Raddr"}, 64'(Raddr), 64'd0);
    endtask

    initial begin
        int          r0;
        logic [44:0] got_b, done_got;
        logic [44:0] want_b;
        int          blen;
        regs = '{8'h00, 8'h5A, 8'hC3, 8'hFF};
        fork
            monitor();
            tracker();
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1 Reset = 1'b0;

        exp_q = {8'h00, 8'h5A, 8'hC3, 8'hFF};
        r0 = runs;
        pulse_start();
        wait_run(r0, "basic");
        check_dump("basic");

        exp_q = {8'h00, 8'h5A, 8'hC3, 8'hFF};
        pulse_start();
        wait_busy("midreset");
        repeat (20) @(negedge clk);
        @(posedge clk); #1 Reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 Reset = 1'b0;
        @(negedge clk);
        check_reset("midreset");
        exp_q = {8'h00, 8'h5A, 8'hC3, 8'hFF};
        r0 = runs;
        pulse_start();
        wait_run(r0, "after reset");
        check_dump("after reset");

        exp_q = {8'h00, 8'h5A, 8'hC3, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'hFF};
        r0 = runs;
        @(posedge clk); #1 Start = 1'b1;
        repeat (300) @(posedge clk);
        #1 Start = 1'b0;
        for (int k = 0; k < 800 && runs < r0 + 2; k++) @(negedge clk);
        repeat (60) @(negedge clk);
        chk("held dumps", 64'(runs - r0), 64'd2);
        chk("held gap", 64'(last_gap), 64'd1);
        chk("held len", 64'(last_len), 64'd165);
        chk("held idle", 64'(Busy), 64'd0);
        chk("held frames left", 64'(exp_q.size()), 64'd0);

        regs = '{8'hA5, 8'h3C, 8'h11, 8'h96};
        exp_q = {8'hA5, 8'h3C, 8'h22, 8'h96};
        r0 = runs;
        pulse_start();
        wait_busy("snapshot");
        repeat (60) @(negedge clk);
        regs[1] = 8'hE7;
        regs[2] = 8'h22;
        wait_run(r0, "snapshot");
        check_dump("snapshot");

        want_b = {{4{11'b101_0000_0011}}, 1'b1};
        got_b = '0;
        done_got = '0;
        blen = 0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 10 && !busy_b; k++) @(negedge clk);
        for (int c = 0; c < 45; c++) begin
            got_b = {got_b[43:0], ser_b};
            done_got = {done_got[43:0], done_b};
            blen += int'(busy_b);
            @(negedge clk);
        end
        chk("cpb1 serial", 64'(got_b), 64'(want_b));
        chk("cpb1 busy len", 64'(blen), 64'd45);
        chk("cpb1 done", 64'(done_got), 64'd1);
        chk("cpb1 idle after", 64'({busy_b, ser_b, raddr_b}), 64'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
